// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 add pipeline.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  // Aligned operands: 24-bit significand followed by guard/round/sticky.
  typedef struct packed {
    logic        special;
    logic [31:0] special_val;
    logic        invalid;
    logic        sign;
    logic        eff_sub;
    logic [7:0]  exp;
    logic [26:0] sig_a;
    logic [26:0] sig_b;
  } s1_t;

  typedef struct packed {
    logic        special;
    logic [31:0] special_val;
    logic        invalid;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;
    logic [4:0]  lzc;
  } s2_t;

  // Subnormals classify as zero (flush-to-zero on input).
  function automatic fp_class_e classify(input fp32_t x);
    if (x.exp == '0) return ZERO;
    if (x.exp == '1) return (x.man != '0) ? NAN : INF;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields W.
module fp_lzc #(
  parameter int W  = 28,
  parameter int CW = 5
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found) begin
        if (d[W-1-i]) found = 1'b1;
        else          cnt   = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Pipelined binary32 adder (RNE, flush-to-zero) with valid/ready flow control
// and sticky {invalid, overflow, inexact} flags.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int FTZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] IN1,
  input  logic [31:0] IN2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] OUT,
  input  logic        flag_clr,
  output logic [2:0]  flags
);

  if (STAGES != 3 || FTZ != 1) begin : g_bad_param
    $error("fp_add_pipe supports only STAGES=3 and FTZ=1");
  end

  logic        adv;
  logic        v0, v1, v2;
  fp32_t       a_q, b_q;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [31:0] res_d;
  logic [2:0]  rflags_d, out_flags;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Operands are registered on acceptance; S1..S3 each end in a register,
  // the last one being OUT itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      OUT       <= '0;
      out_flags <= '0;
    end else if (adv) begin
      v0 <= in_valid;
      if (in_valid) begin
        a_q <= IN1;
        b_q <= IN2;
      end
      v1        <= v0;
      s1_q      <= s1_d;
      v2        <= v1;
      s2_q      <= s2_d;
      out_valid <= v2;
      OUT       <= res_d;
      out_flags <= rflags_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= '0;
    else     flags <= (flag_clr ? 3'b000 : flags) | ((out_valid && out_ready) ? out_flags : 3'b000);
  end

  // S1: classify, order by magnitude, align the smaller operand.
  fp_class_e   ca, cb;
  logic [30:0] mag_a, mag_b;
  logic        swap, sign_x;
  logic [7:0]  exp_x, exp_y, diff;
  logic [22:0] man_x, man_y;
  logic [4:0]  shamt;
  logic [26:0] sig_y, ones;

  always_comb begin
    ca     = classify(a_q);
    cb     = classify(b_q);
    mag_a  = (ca == ZERO) ? '0 : {a_q.exp, a_q.man};
    mag_b  = (cb == ZERO) ? '0 : {b_q.exp, b_q.man};
    swap   = mag_b > mag_a;
    sign_x = swap ? b_q.sign : a_q.sign;
    exp_x  = swap ? b_q.exp  : a_q.exp;
    exp_y  = swap ? a_q.exp  : b_q.exp;
    man_x  = swap ? b_q.man  : a_q.man;
    man_y  = swap ? a_q.man  : b_q.man;
    sig_y  = ((swap ? ca : cb) == ZERO) ? '0 : {1'b1, man_y, 3'b000};
    diff   = exp_x - exp_y;
    shamt  = (diff > 8'd27) ? 5'd27 : diff[4:0];
    ones   = '1;

    s1_d         = '0;
    s1_d.sign    = sign_x;
    s1_d.eff_sub = a_q.sign ^ b_q.sign;
    s1_d.exp     = exp_x;
    s1_d.sig_a   = {1'b1, man_x, 3'b000};
    s1_d.sig_b   = (sig_y >> shamt) | {26'b0, |(sig_y & ~(ones << shamt))};

    if (ca == NAN || cb == NAN || (ca == INF && cb == INF && a_q.sign != b_q.sign)) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = CANON_NAN;
      s1_d.invalid     = 1'b1;
    end else if (ca == INF) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = a_q;
    end else if (cb == INF) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = b_q;
    end else if (ca == ZERO && cb == ZERO) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = {a_q.sign & b_q.sign, 31'b0};
    end
  end

  // S2: magnitude add/subtract and leading-zero count.
  logic [27:0] sum_w;
  logic [4:0]  lzc_cnt;

  assign sum_w = s1_q.eff_sub ? ({1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b})
                              : ({1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b});

  fp_lzc #(.W(28), .CW(5)) u_lzc (.d(sum_w), .cnt(lzc_cnt));

  always_comb begin
    s2_d             = '0;
    s2_d.special     = s1_q.special;
    s2_d.special_val = s1_q.special_val;
    s2_d.invalid     = s1_q.invalid;
    s2_d.sign        = s1_q.sign;
    s2_d.exp         = s1_q.exp;
    s2_d.sum         = sum_w;
    s2_d.lzc         = lzc_cnt;
  end

  // S3: normalise, round to nearest even, pack.
  logic [26:0]        norm;
  logic signed [9:0]  exp_n, exp_r;
  logic [24:0]        mant;
  logic [22:0]        frac;
  logic               rnd_up, inexact;

  always_comb begin
    if (s2_q.lzc == '0) norm = {s2_q.sum[27:2], |s2_q.sum[1:0]};
    else                norm = s2_q.sum[26:0] << (s2_q.lzc - 5'd1);
    exp_n   = $signed(10'(s2_q.exp) + 10'd1 - 10'(s2_q.lzc));
    inexact = |norm[2:0];
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant    = {1'b0, norm[26:3]} + 25'(rnd_up);
    if (mant[24]) begin
      exp_r = exp_n + 10'sd1;
      frac  = mant[23:1];
    end else begin
      exp_r = exp_n;
      frac  = mant[22:0];
    end

    res_d    = '0;
    rflags_d = '0;
    if (s2_q.special) begin
      res_d    = s2_q.special_val;
      rflags_d = {s2_q.invalid, 2'b00};
    end else if (s2_q.sum == '0) begin
      res_d    = '0;
    end else if (exp_r >= 10'sd255) begin
      res_d    = {s2_q.sign, 8'hFF, 23'b0};
      rflags_d = 3'b011;
    end else if (exp_r <= 10'sd0) begin
      res_d    = {s2_q.sign, 31'b0};
      rflags_d = 3'b001;
    end else begin
      res_d    = {s2_q.sign, exp_r[7:0], frac};
      rflags_d = {2'b00, inexact};
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed self-checking bench for fp_add_pipe.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, flag_clr;
  logic [31:0] IN1, IN2, OUT;
  logic [2:0]  flags;

  int checks   = 0;
  int failures = 0;
  int sent, rcv;
  logic [31:0] held;
  logic        held_ok;
  logic [31:0] va [6];
  logic [31:0] vb [6];
  logic [31:0] vr [6];

  always #5 clk = ~clk;

  fp_add_pipe #(.STAGES(3), .FTZ(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .IN1      (IN1),
    .IN2      (IN2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .OUT      (OUT),
    .flag_clr (flag_clr),
    .flags    (flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Single op with out_ready held high; checks latency, result, flags.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input logic [2:0] want_flags, input bit clr);
    int   lat;
    logic seen;
    @(posedge clk); #1;
    in_valid = 1'b1; IN1 = a; IN2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = out_valid;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk(tag, OUT, want);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_flags"}, 32'(flags), 32'(want_flags));
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    if (clr) begin
      @(posedge clk); #1;
      flag_clr = 1'b1;
      @(posedge clk); #1;
      flag_clr = 1'b0;
      @(negedge clk);
      chk({tag, "_clr"}, 32'(flags), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    va = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    vb = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    vr = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    IN1 = '0; IN2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out",       OUT,            32'd0);
    chk("rst_flags",     32'(flags),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op("one_plus_two", 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 1'b1);
    do_op("rne_tie",      32'h4B800000, 32'h3F800000, 32'h4B800000, 3'b001, 1'b1);
    do_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b011, 1'b1);
    do_op("inf_minus_inf",32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100, 1'b1);
    do_op("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 1'b1);
    do_op("inf_plus_fin", 32'h3F800000, 32'hFF800000, 32'hFF800000, 3'b000, 1'b1);
    do_op("cancel",       32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000, 1'b1);
    do_op("neg_zeros",    32'h80000000, 32'h80000000, 32'h80000000, 3'b000, 1'b1);
    do_op("ftz_in",       32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000, 1'b1);
    do_op("sub_norm",     32'h40400000, 32'hC0000000, 32'h3F800000, 3'b000, 1'b1);

    // Back-pressure: out_ready low for 4 cycles while ops are streaming.
    sent = 0; rcv = 0; held = '0; held_ok = 1'b0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 5 && c <= 8);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        IN1 = va[sent];
        IN2 = vb[sent];
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d", rcv), OUT, vr[rcv]);
        rcv++;
      end
      if (!out_ready) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        if (held_ok) chk("bp_stable", OUT, held);
        else begin
          held    = OUT;
          held_ok = 1'b1;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 32'(rcv), 32'd6);
    chk("bp_sent",  32'(sent), 32'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Reset with three ops in flight and the inexact flag set.
    do_op("rne_pre_rst", 32'h4B800000, 32'h3F800000, 32'h4B800000, 3'b001, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; IN1 = 32'h3F800000; IN2 = 32'h40000000;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_flags", 32'(flags),     32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_flags", 32'(flags),     32'd0);
    chk("async_rst_out",   OUT,            32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    do_op("post_rst", 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
